// File: rtl/parallel_serializer_pkg.sv
// Shared types and constants for the parallel-to-serial converter.
package parallel_serializer_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    PARITY = 2'd2,
    GAP    = 2'd3
  } state_t;

  // Inter-frame gap counter width; GAP_CYCLES tops out at 15.
  localparam int GAP_CNT_W = 4;

endpackage

// File: rtl/piso_shift_reg.sv
// Parallel-in serial-out shift register with a running even-parity tap.
module piso_shift_reg
  import parallel_serializer_pkg::*;
#(
  parameter int WIDTH     = 32,
  parameter int LSB_FIRST = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             shift_en,
  input  logic [WIDTH-1:0] din,
  output logic             sout,
  output logic             parity
);

  logic [WIDTH-1:0] sreg;

  assign sout = (LSB_FIRST != 0) ? sreg[0] : sreg[WIDTH-1];

  // Load wins over shift; parity folds in each bit as it leaves the register,
  // so after the last shift it covers exactly the captured word.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sreg   <= '0;
      parity <= 1'b0;
    end else if (load) begin
      sreg   <= din;
      parity <= 1'b0;
    end else if (shift_en) begin
      sreg   <= (LSB_FIRST != 0) ? {1'b0, sreg[WIDTH-1:1]} : {sreg[WIDTH-2:0], 1'b0};
      parity <= parity ^ sout;
    end
  end

endmodule

// File: rtl/parallel_serializer.sv
// Word-to-bitstream converter with req/grant intake, optional parity trailer
// and programmable inter-frame gap.
module parallel_serializer
  import parallel_serializer_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int LSB_FIRST  = 1,
  parameter int PARITY_EN  = 0,
  parameter int GAP_CYCLES = 0
) (
  input  logic                  p_clk,
  input  logic                  rst,
  input  logic                  req,
  input  logic [DATA_WIDTH-1:0] parallel_data_in,
  output logic                  grant,
  output logic                  serial_data_out,
  output logic                  out_data,
  output logic                  frame_start,
  output logic                  frame_end,
  output logic                  busy
);

  localparam int CNT_W = $clog2(DATA_WIDTH);
  localparam logic [CNT_W-1:0]     CNT_LAST = CNT_W'(DATA_WIDTH - 1);
  localparam logic [GAP_CNT_W-1:0] GAP_LAST =
    GAP_CNT_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  state_t               state, state_n;
  logic [CNT_W-1:0]     cnt, cnt_n;
  logic [GAP_CNT_W-1:0] gcnt, gcnt_n;
  logic                 grant_n, load, shift_en, last_bit;
  logic                 sr_bit, par_bit;

  piso_shift_reg #(
    .WIDTH    (DATA_WIDTH),
    .LSB_FIRST(LSB_FIRST)
  ) u_sr (
    .clk     (p_clk),
    .rst     (rst),
    .load    (load),
    .shift_en(shift_en),
    .din     (parallel_data_in),
    .sout    (sr_bit),
    .parity  (par_bit)
  );

  // State and counter registers; grant is a registered one-cycle pulse.
  always_ff @(posedge p_clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      gcnt  <= '0;
      grant <= 1'b0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      gcnt  <= gcnt_n;
      grant <= grant_n;
    end
  end

  // Next-state logic. Any frame end with no gap, or the final gap cycle,
  // may capture immediately so held req gives gap-free back-to-back frames.
  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    gcnt_n   = gcnt;
    grant_n  = 1'b0;
    load     = 1'b0;
    shift_en = 1'b0;
    last_bit = 1'b0;
    case (state)
      IDLE: if (req) load = 1'b1;
      SHIFT: begin
        shift_en = 1'b1;
        if (cnt == CNT_LAST) begin
          if (PARITY_EN != 0) state_n = PARITY;
          else                last_bit = 1'b1;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      PARITY: last_bit = 1'b1;
      GAP: begin
        if (gcnt == GAP_LAST) begin
          state_n = IDLE;
          if (req) load = 1'b1;
        end else begin
          gcnt_n = gcnt + 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
    if (last_bit) begin
      if (GAP_CYCLES > 0) begin
        state_n = GAP;
        gcnt_n  = '0;
      end else begin
        state_n = IDLE;
        if (req) load = 1'b1;
      end
    end
    if (load) begin
      state_n = SHIFT;
      cnt_n   = '0;
      grant_n = 1'b1;
    end
  end

  assign out_data        = (state == SHIFT) || (state == PARITY);
  assign serial_data_out = (state == SHIFT) ? sr_bit : ((state == PARITY) ? par_bit : 1'b0);
  assign frame_start     = (state == SHIFT) && (cnt == '0);
  assign frame_end       = ((state == SHIFT) && (cnt == CNT_LAST) && (PARITY_EN == 0)) ||
                           (state == PARITY);
  assign busy            = (state != IDLE);

endmodule

// File: tb/tb_parallel_serializer.sv
// Bench for parallel_serializer: four instances cover LSB-first, MSB-first,
// parity trailer and a 3-cycle inter-frame gap. Expected bits are queued at
// stimulus time and popped as out_data reports bits.
module tb_parallel_serializer;

  typedef struct {
    logic b;
    logic fs;
    logic fe;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  req = '0;
  logic [31:0] pdata [4];
  logic [3:0]  grant, sdo, od, fs, fe, busy;

  int checks = 0;
  int errors = 0;

  exp_t        exp_q[$];
  int          grant_q[$];
  int          first_out, last_out, out_cnt, low_in, busy_low_in, pos;
  logic        busy_after;
  logic [63:0] bits_seen;

  always #5 clk = ~clk;

  for (genvar gi = 0; gi < 4; gi++) begin : g_dut
    parallel_serializer #(
      .DATA_WIDTH(32),
      .LSB_FIRST ((gi == 1) ? 0 : 1),
      .PARITY_EN ((gi == 2) ? 1 : 0),
      .GAP_CYCLES((gi == 3) ? 3 : 0)
    ) u_dut (
      .p_clk           (clk),
      .rst             (rst),
      .req             (req[gi]),
      .parallel_data_in(pdata[gi]),
      .grant           (grant[gi]),
      .serial_data_out (sdo[gi]),
      .out_data        (od[gi]),
      .frame_start     (fs[gi]),
      .frame_end       (fe[gi]),
      .busy            (busy[gi])
    );
  end

  function automatic bit lsb_of(input int u); return u != 1; endfunction
  function automatic bit par_of(input int u); return u == 2; endfunction
  function automatic int gap_of(input int u); return (u == 3) ? 3 : 0; endfunction

  task automatic push_word(input int u, input logic [31:0] w);
    exp_t e;
    for (int i = 0; i < 32; i++) begin
      e.b  = lsb_of(u) ? w[i] : w[31-i];
      e.fs = (i == 0);
      e.fe = (i == 31) && !par_of(u);
      exp_q.push_back(e);
    end
    if (par_of(u)) begin
      e.b  = ^w;
      e.fs = 1'b0;
      e.fe = 1'b1;
      exp_q.push_back(e);
    end
  endtask

  // Drive nw words on unit u with req held until the last grant; scoreboard every cycle.
  task automatic run(input int u, input int nw, input logic [31:0] w0, input logic [31:0] w1);
    int   ncyc, sent;
    exp_t e;
    exp_q.delete();
    grant_q.delete();
    first_out = -1; last_out = -1; out_cnt = 0; low_in = 0; busy_low_in = 0; pos = 0;
    bits_seen = '0; busy_after = 1'bx;
    push_word(u, w0);
    if (nw > 1) push_word(u, w1);
    ncyc = nw * (32 + (par_of(u) ? 1 : 0) + gap_of(u)) + 8;
    @(negedge clk);
    req[u] = 1'b1; pdata[u] = w0; sent = 1;
    for (int c = 1; c <= ncyc; c++) begin
      @(negedge clk);
      if (grant[u]) begin
        grant_q.push_back(c);
        if (sent < nw) begin pdata[u] = w1; sent++; end
        else req[u] = 1'b0;
      end
      checks++;
      if (od[u]) begin
        if (first_out < 0) first_out = c;
        last_out = c;
        out_cnt++;
        if (pos < 64) bits_seen[pos] = sdo[u];
        pos++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL u%0d extra_bit cycle %0d got bit %b required none", u, c, sdo[u]);
        end else begin
          e = exp_q.pop_front();
          if ({sdo[u], fs[u], fe[u]} !== {e.b, e.fs, e.fe}) begin
            errors++;
            $display("FAIL u%0d bit cycle %0d got {bit,fs,fe}=%b%b%b required %b%b%b",
                     u, c, sdo[u], fs[u], fe[u], e.b, e.fs, e.fe);
          end
        end
      end else begin
        if ({sdo[u], fs[u], fe[u]} !== 3'b000) begin
          errors++;
          $display("FAIL u%0d idle_outputs cycle %0d got %b%b%b required 000", u, c, sdo[u], fs[u], fe[u]);
        end
        if (first_out >= 0 && exp_q.size() != 0) begin
          low_in++;
          if (!busy[u]) busy_low_in++;
        end
        if (last_out >= 0 && c == last_out + 1) busy_after = busy[u];
      end
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL u%0d missing_bits got %0d left required 0", u, exp_q.size());
    end
    checks++;
    if (grant_q.size() != nw) begin
      errors++;
      $display("FAIL u%0d grant_count got %0d required %0d", u, grant_q.size(), nw);
    end
  endtask

  task automatic check_zero(input string name, input int u);
    checks++;
    if ({grant[u], sdo[u], od[u], fs[u], fe[u], busy[u]} !== 6'b0) begin
      errors++;
      $display("FAIL %s u%0d got %b required 000000", name, u,
               {grant[u], sdo[u], od[u], fs[u], fe[u], busy[u]});
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    for (int u = 0; u < 4; u++) check_zero("reset_state", u);
    rst = 1'b0;
    @(negedge clk);
    #1 rst = 1'b1;
    #1 check_zero("reset_idle", 0);
    #1 rst = 1'b0;
    @(negedge clk);
    req[0] = 1'b1; pdata[0] = 32'hFFFF_FFFF;
    repeat (5) @(posedge clk);
    @(negedge clk);
    req[0] = 1'b0;
    checks++;
    if (od[0] !== 1'b1) begin
      errors++;
      $display("FAIL reset_pre_frame got out_data %b required 1", od[0]);
    end
    #1 rst = 1'b1;
    #1 check_zero("reset_mid_frame", 0);
    @(negedge clk);
    check_zero("reset_held", 0);
    rst = 1'b0;
    run(0, 1, 32'h8000_0002, 32'h0);
    checks++;
    if (bits_seen[1:0] !== 2'b10 || first_out != 1) begin
      errors++;
      $display("FAIL reset_fresh_frame got bits %b first %0d required 10 first 1", bits_seen[1:0], first_out);
    end
  endtask

  task automatic test_lsb_first();
    run(0, 1, 32'hA5A5_0F01, 32'h0);
    checks++;
    if (grant_q.size() < 1 || grant_q[0] != 1) begin
      errors++; $display("FAIL lsb_grant_cycle got %0d required 1", (grant_q.size() > 0) ? grant_q[0] : -1);
    end
    checks++;
    if (bits_seen[12:0] !== 13'h0F01) begin
      errors++; $display("FAIL lsb_bits got %h required 0f01", bits_seen[12:0]);
    end
    checks++;
    if (last_out != 32 || out_cnt != 32) begin
      errors++; $display("FAIL lsb_frame_end got last %0d count %0d required 32 32", last_out, out_cnt);
    end
    checks++;
    if (busy_after !== 1'b0) begin
      errors++; $display("FAIL lsb_idle_after got busy %b required 0", busy_after);
    end
  endtask

  task automatic test_msb_first();
    run(1, 1, 32'hA5A5_0F01, 32'h0);
    checks++;
    if (bits_seen[7:0] !== 8'hA5 || bits_seen[31] !== 1'b1) begin
      errors++; $display("FAIL msb_bits got %h last %b required a5 last 1", bits_seen[7:0], bits_seen[31]);
    end
  endtask

  task automatic test_parity();
    run(2, 1, 32'h0000_0007, 32'h0);
    checks++;
    if (bits_seen[32] !== 1'b1 || out_cnt != 33 || last_out != 33) begin
      errors++; $display("FAIL parity_odd got p %b count %0d last %0d required 1 33 33", bits_seen[32], out_cnt, last_out);
    end
    run(2, 1, 32'h0000_0003, 32'h0);
    checks++;
    if (bits_seen[32] !== 1'b0 || out_cnt != 33) begin
      errors++; $display("FAIL parity_even got p %b count %0d required 0 33", bits_seen[32], out_cnt);
    end
  endtask

  task automatic test_back_to_back();
    run(0, 2, 32'hFFFF_FFFF, 32'h0000_0000);
    checks++;
    if (grant_q.size() != 2 || grant_q[0] != 1 || grant_q[1] != 33) begin
      errors++; $display("FAIL b2b_grants got %0d grants first %0d required 1 and 33",
                         grant_q.size(), (grant_q.size() > 0) ? grant_q[0] : -1);
    end
    checks++;
    if (out_cnt != 64 || first_out != 1 || last_out != 64 || low_in != 0) begin
      errors++; $display("FAIL b2b_contiguous got count %0d first %0d last %0d gaps %0d required 64 1 64 0",
                         out_cnt, first_out, last_out, low_in);
    end
  endtask

  task automatic test_gap();
    run(3, 2, 32'h1234_5678, 32'h9ABC_DEF0);
    checks++;
    if (low_in != 3 || busy_low_in != 0) begin
      errors++; $display("FAIL gap_len got low %0d busy_low %0d required 3 0", low_in, busy_low_in);
    end
    checks++;
    if (grant_q.size() != 2 || grant_q[1] != 36) begin
      errors++; $display("FAIL gap_grant2 got %0d required 36", (grant_q.size() > 1) ? grant_q[1] : -1);
    end
  endtask

  initial begin
    for (int u = 0; u < 4; u++) pdata[u] = '0;
    test_reset();
    test_lsb_first();
    test_msb_first();
    test_parity();
    test_back_to_back();
    test_gap();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
